// File: rtl/rs232_player_pkg.sv
// Shared definitions for the RS-232 tap OUT-buffer playback engine:
// command codes, record layout, tap line bit map and FSM state encodings.
package rs232_player_pkg;

  localparam int BUF_AW    = 9;
  localparam int LEN_W     = 10;
  localparam int REC_BYTES = 8;

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_APPLY   = 8'h01;
  localparam logic [7:0] CMD_RELEASE = 8'h02;

  // Big-endian record: byte 0 lands in the top of the 64-bit register.
  localparam int REC_CMD_LSB   = 56;
  localparam int REC_DELAY_LSB = 32;
  localparam int REC_MASK_LSB  = 16;
  localparam int REC_LEVEL_LSB = 0;

  localparam int LINE_A_RTS = 15;
  localparam int LINE_A_TXD = 14;
  localparam int LINE_A_DTR = 13;
  localparam int LINE_B_RXD = 12;
  localparam int LINE_B_CTS = 11;
  localparam int LINE_B_CD  = 10;
  localparam int LINE_B_RI  = 9;
  localparam int LINE_B_DSR = 8;
  localparam int LINE_C_RTS = 7;
  localparam int LINE_C_TXD = 6;
  localparam int LINE_C_DTR = 5;
  localparam int LINE_D_RXD = 4;
  localparam int LINE_D_CTS = 3;
  localparam int LINE_D_CD  = 2;
  localparam int LINE_D_RI  = 1;
  localparam int LINE_D_DSR = 0;

  localparam logic [15:0] LINES_A = 16'hE000;
  localparam logic [15:0] LINES_B = 16'h1F00;
  localparam logic [15:0] LINES_C = 16'h00E0;
  localparam logic [15:0] LINES_D = 16'h001F;

  typedef enum logic [5:0] {
    ST_RST     = 6'd0,
    ST_ARM     = 6'd1,
    ST_ARM_ACK = 6'd2,
    ST_WAIT    = 6'd3,
    ST_FETCH   = 6'd4,
    ST_DELAY   = 6'd5,
    ST_APPLY   = 6'd6
  } state_e;

  // Replace only the masked bits of a line vector.
  function automatic logic [15:0] merge_lines(input logic [15:0] cur,
                                              input logic [15:0] mask,
                                              input logic [15:0] level);
    return (cur & ~mask) | (level & mask);
  endfunction

endpackage

// File: rtl/rs232_player_sync.sv
// Two-flop synchronizer for single-bit control inputs arriving from the USB domain.
module rs232_player_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // NOTE: flops use non-blocking assignment so both stages sample the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/rs232_out_player.sv
// Plays 8-byte command records from the USB OUT buffer onto the tap override lines.
// Define RS232_PLAYER_ERRCNT_EN to build the error counter; otherwise err_count is 0.
module rs232_out_player
  import rs232_player_pkg::*;
(
  input  logic               clk_50,
  input  logic               reset_n,
  output logic [BUF_AW-1:0]  buf_out_addr,
  input  logic [7:0]         buf_out_q,
  input  logic [LEN_W-1:0]   buf_out_len,
  input  logic               buf_out_hasdata,
  output logic               buf_out_arm,
  input  logic               buf_out_arm_ack,
  input  logic               usb_configured,
  output logic [15:0]        ovr_en,
  output logic [15:0]        ovr_val,
  output logic               busy,
  output logic [15:0]        rec_count,
  output logic [7:0]         err_count
);

  state_e      state_q;
  logic [8:0]  addr_q;
  logic        arm_q;
  logic        busy_q;
  logic [15:0] ovr_en_q;
  logic [15:0] ovr_val_q;
  logic [15:0] rec_count_q;
  logic [63:0] rec_q;
  logic [63:0] rec_d;
  logic [6:0]  rec_idx_q;
  logic [6:0]  last_idx_q;
  logic [3:0]  fcnt_q;
  logic [23:0] dly_q;
  logic [6:0]  n_rec;
  logic [15:0] rec_mask;
  logic [15:0] rec_level;
  logic        hasdata_s;
  logic        ack_s;

  rs232_player_sync u_sync_hasdata (
    .clk   (clk_50),
    .rst_n (reset_n),
    .d_i   (buf_out_hasdata),
    .q_o   (hasdata_s)
  );

  rs232_player_sync u_sync_ack (
    .clk   (clk_50),
    .rst_n (reset_n),
    .d_i   (buf_out_arm_ack),
    .q_o   (ack_s)
  );

  assign rec_d     = {rec_q[55:0], buf_out_q};
  assign n_rec     = 7'(buf_out_len >> 3);
  assign rec_mask  = rec_q[REC_MASK_LSB +: 16];
  assign rec_level = rec_q[REC_LEVEL_LSB +: 16];

`ifdef RS232_PLAYER_ERRCNT_EN
  logic [7:0] err_q;
  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RST;
      addr_q      <= '0;
      arm_q       <= 1'b0;
      busy_q      <= 1'b1;
      ovr_en_q    <= '0;
      ovr_val_q   <= '0;
      rec_count_q <= '0;
      rec_q       <= '0;
      rec_idx_q   <= '0;
      last_idx_q  <= '0;
      fcnt_q      <= '0;
      dly_q       <= '0;
`ifdef RS232_PLAYER_ERRCNT_EN
      err_q       <= '0;
`endif
    end else if (!usb_configured && state_q != ST_RST) begin
      // Losing configuration drops all overrides and abandons the buffer.
      state_q  <= ST_ARM;
      arm_q    <= 1'b0;
      busy_q   <= 1'b1;
      ovr_en_q <= '0;
    end else begin
      case (state_q)
        ST_RST: state_q <= ST_ARM;

        ST_ARM: begin
          if (arm_q && ack_s) begin
            arm_q   <= 1'b0;
            state_q <= ST_ARM_ACK;
          end else begin
            arm_q <= 1'b1;
          end
        end

        ST_ARM_ACK: begin
          if (!ack_s) begin
            state_q <= ST_WAIT;
            busy_q  <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (hasdata_s) begin
            busy_q     <= 1'b1;
            rec_idx_q  <= '0;
            last_idx_q <= n_rec - 7'd1;
`ifdef RS232_PLAYER_ERRCNT_EN
            if (buf_out_len[2:0] != 3'd0 && err_q != 8'hFF) err_q <= err_q + 8'd1;
`endif
            if (n_rec == 7'd0) begin
              state_q <= ST_ARM;
            end else begin
              state_q <= ST_FETCH;
              addr_q  <= '0;
              fcnt_q  <= '0;
            end
          end
        end

        // Addresses go out on fcnt 0..7; read data trails by two cycles.
        ST_FETCH: begin
          fcnt_q <= fcnt_q + 4'd1;
          if (fcnt_q < 4'd7) addr_q <= addr_q + 9'd1;
          if (fcnt_q >= 4'd2) rec_q <= rec_d;
          if (fcnt_q == 4'd9) begin
            dly_q   <= rec_d[REC_DELAY_LSB +: 24];
            state_q <= ST_DELAY;
          end
        end

        // The command is applied on the edge into ST_APPLY so it is visible during it.
        ST_DELAY: begin
          if (dly_q == 24'd0) begin
            state_q <= ST_APPLY;
            case (rec_q[REC_CMD_LSB +: 8])
              CMD_NOP: ;
              CMD_APPLY: begin
                ovr_en_q    <= ovr_en_q | rec_mask;
                ovr_val_q   <= merge_lines(ovr_val_q, rec_mask, rec_level);
                rec_count_q <= rec_count_q + 16'd1;
              end
              CMD_RELEASE: begin
                ovr_en_q    <= ovr_en_q & ~rec_mask;
                rec_count_q <= rec_count_q + 16'd1;
              end
              default: begin
`ifdef RS232_PLAYER_ERRCNT_EN
                if (err_q != 8'hFF) err_q <= err_q + 8'd1;
`endif
              end
            endcase
          end else begin
            dly_q <= dly_q - 24'd1;
          end
        end

        ST_APPLY: begin
          if (rec_idx_q == last_idx_q) begin
            state_q <= ST_ARM;
          end else begin
            rec_idx_q <= rec_idx_q + 7'd1;
            addr_q    <= {rec_idx_q + 7'd1, 3'd0};
            fcnt_q    <= '0;
            state_q   <= ST_FETCH;
          end
        end

        default: state_q <= ST_RST;
      endcase
    end
  end

  assign buf_out_addr = addr_q;
  assign buf_out_arm  = arm_q;
  assign busy         = busy_q;
  assign ovr_en       = ovr_en_q;
  assign ovr_val      = ovr_val_q;
  assign rec_count    = rec_count_q;

endmodule

// File: tb/tb_rs232_out_player.sv
// Directed bench for rs232_out_player: acts as USB host and OUT buffer (2-cycle read latency).
module tb_rs232_out_player;

  logic        clk_50 = 1'b0;
  logic        reset_n;
  logic [8:0]  buf_out_addr;
  logic [7:0]  buf_out_q;
  logic [9:0]  buf_out_len;
  logic        buf_out_hasdata;
  logic        buf_out_arm;
  logic        buf_out_arm_ack;
  logic        usb_configured;
  logic [15:0] ovr_en;
  logic [15:0] ovr_val;
  logic        busy;
  logic [15:0] rec_count;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [512];
  logic [7:0] rd_p1;

  rs232_out_player dut (
    .clk_50          (clk_50),
    .reset_n         (reset_n),
    .buf_out_addr    (buf_out_addr),
    .buf_out_q       (buf_out_q),
    .buf_out_len     (buf_out_len),
    .buf_out_hasdata (buf_out_hasdata),
    .buf_out_arm     (buf_out_arm),
    .buf_out_arm_ack (buf_out_arm_ack),
    .usb_configured  (usb_configured),
    .ovr_en          (ovr_en),
    .ovr_val         (ovr_val),
    .busy            (busy),
    .rec_count       (rec_count),
    .err_count       (err_count)
  );

  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) begin
    rd_p1     <= mem[buf_out_addr];
    buf_out_q <= rd_p1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic put_rec(input int idx, input logic [63:0] r);
    for (int b = 0; b < 8; b++) mem[idx*8 + b] = r[63 - 8*b -: 8];
  endtask

  // Host side of the 4-phase arm handshake, ending once the player is idle.
  task automatic host_arm();
    int n;
    n = 0;
    while (buf_out_arm !== 1'b1 && n < 40) begin tick(1); n++; end
    check("arm_up", buf_out_arm, 1);
    buf_out_arm_ack = 1'b1;
    n = 0;
    while (buf_out_arm !== 1'b0 && n < 40) begin tick(1); n++; end
    check("arm_down", buf_out_arm, 0);
    buf_out_arm_ack = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin tick(1); n++; end
    check("idle", busy, 0);
  endtask

  // Present a filled buffer; returns at the mid-point of cycle F0.
  task automatic start_buf(input logic [9:0] len);
    buf_out_len     = len;
    buf_out_hasdata = 1'b1;
    tick(3);
    buf_out_hasdata = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_err;
`ifdef RS232_PLAYER_ERRCNT_EN
    exp_err = 8'd2;
`else
    exp_err = 8'd0;
`endif
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    reset_n         = 1'b0;
    buf_out_len     = '0;
    buf_out_hasdata = 1'b0;
    buf_out_arm_ack = 1'b0;
    usb_configured  = 1'b0;
    tick(3);
    check("rst_addr", buf_out_addr, 0);
    check("rst_arm", buf_out_arm, 0);
    check("rst_en", ovr_en, 0);
    check("rst_val", ovr_val, 0);
    check("rst_busy", busy, 1);
    check("rst_rec", rec_count, 0);
    check("rst_err", err_count, 0);
    reset_n        = 1'b1;
    usb_configured = 1'b1;

    // One APPLY record, zero delay.
    put_rec(0, 64'h01_000000_FFFF_5555);
    host_arm();
    start_buf(10'd8);
    check("t1_addr0", buf_out_addr, 9'd0);
    tick(7);
    check("t1_addr7", buf_out_addr, 9'd7);
    tick(3);
    check("t1_en_f10", ovr_en, 16'h0000);
    tick(1);
    check("t1_en_f11", ovr_en, 16'hFFFF);
    check("t1_val_f11", ovr_val, 16'h5555);
    check("t1_rec", rec_count, 16'd1);
    host_arm();

    // Asynchronous reset during a long delay.
    put_rec(0, 64'h01_000100_00FF_00AA);
    start_buf(10'd8);
    tick(15);
    check("t2_busy_delay", busy, 1);
    reset_n = 1'b0;
    #1;
    check("t2_en", ovr_en, 16'h0000);
    check("t2_val", ovr_val, 16'h0000);
    check("t2_busy", busy, 1);
    check("t2_arm", buf_out_arm, 0);
    check("t2_rec", rec_count, 16'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("t2_rst_arm", buf_out_arm, 0);
    tick(1);
    check("t2_arm_again", buf_out_arm, 1);
    host_arm();

    // APPLY with delay 100, then RELEASE.
    put_rec(0, 64'h01_000064_A000_2000);
    put_rec(1, 64'h02_000000_8000_0000);
    start_buf(10'd16);
    tick(110);
    check("t3_en_f110", ovr_en, 16'h0000);
    tick(1);
    check("t3_en_f111", ovr_en, 16'hA000);
    check("t3_val_f111", ovr_val, 16'h2000);
    tick(1);
    check("t3_rec1_addr", buf_out_addr, 9'd8);
    tick(10);
    check("t3_en_f122", ovr_en, 16'hA000);
    tick(1);
    check("t3_en_f123", ovr_en, 16'h2000);
    check("t3_val_f123", ovr_val, 16'h2000);
    check("t3_rec", rec_count, 16'd2);
    host_arm();

    // Empty buffer: straight back to arm.
    buf_out_len     = 10'd0;
    buf_out_hasdata = 1'b1;
    tick(3);
    buf_out_hasdata = 1'b0;
    tick(1);
    check("t4_addr", buf_out_addr, 9'd15);
    check("t4_arm", buf_out_arm, 1);
    check("t4_rec", rec_count, 16'd2);
    check("t4_err", err_count, 0);
    host_arm();

    // len=13 with unknown command 0x7E.
    put_rec(0, 64'h7E_000003_FFFF_FFFF);
    start_buf(10'd13);
    tick(14);
    check("t5_en", ovr_en, 16'h2000);
    check("t5_val", ovr_val, 16'h2000);
    check("t5_rec", rec_count, 16'd2);
    check("t5_err", err_count, exp_err);
    host_arm();

    // usb_configured drops mid-fetch.
    put_rec(0, 64'h01_000000_00FF_00FF);
    start_buf(10'd8);
    tick(3);
    usb_configured = 1'b0;
    tick(1);
    check("t6_en", ovr_en, 16'h0000);
    check("t6_val", ovr_val, 16'h2000);
    check("t6_arm", buf_out_arm, 0);
    check("t6_busy", busy, 1);
    tick(10);
    check("t6_arm_hold", buf_out_arm, 0);
    check("t6_en_hold", ovr_en, 16'h0000);
    usb_configured = 1'b1;
    host_arm();
    tick(20);
    check("t6_en_final", ovr_en, 16'h0000);
    check("t6_rec_final", rec_count, 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs232_out_player.md
# rs232_out_player

Playback engine for the RS-232 tap. It consumes 8-byte command records that the host writes into the USB 2.0 bulk OUT buffer and drives timed override levels onto the 16 tap output lines (A/C DCE outputs, B/D DTE outputs). It is the OUT-direction counterpart of the tap's status capture path, which records line changes into the IN buffer. It sits in the `clk_50` domain between `usb2_top`'s `buf_out_*` port and the top-level pass-through/override muxes.

## Interface
- No parameters. Buffer depth is fixed at 512 bytes and the record size at 8 bytes.
- `clk_50` in 1: 50 MHz system clock, the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `buf_out_addr` out 9: OUT buffer byte address. Reset value 0.
- `buf_out_q` in 8: OUT buffer read data, valid 2 cycles after the address is presented.
- `buf_out_len` in 10: byte count of the filled buffer. Stable while `buf_out_hasdata` is high.
- `buf_out_hasdata` in 1: buffer holds host data. Asynchronous to `clk_50`.
- `buf_out_arm` out 1: request to hand the buffer back to the host. Reset value 0.
- `buf_out_arm_ack` in 1: arm acknowledge. Asynchronous to `clk_50`.
- `usb_configured` in 1: no buffer traffic occurs while low.
- `ovr_en` out 16: per-line override enable. Reset value 0 (all lines pass through).
- `ovr_val` out 16: per-line override level. Reset value 0.
- `busy` out 1: high in any state other than ST_WAIT. Reset value 1.
- `rec_count` out 16: count of applied records, wraps at 16 bits. Reset value 0.
- `err_count` out 8: count of errors, saturates at 0xFF. Reset value 0.

## Operation
- Record format, bytes 0 to 7, big-endian: `{cmd[63:56], delay[55:32], mask[31:16], level[15:0]}`.
- Line bit map for mask and level: [15:13] A RTS/TXD/DTR, [12:8] B RXD/CTS/CD/RI/DSR, [7:5] C RTS/TXD/DTR, [4:0] D RXD/CTS/CD/RI/DSR.
- cmd 0x00 NOP: waits `delay`, then does nothing.
- cmd 0x01 APPLY: for each bit set in `mask`, sets `ovr_en`=1 and `ovr_val`=`level`. Bits clear in `mask` are unchanged.
- cmd 0x02 RELEASE: sets `ovr_en` to `ovr_en & ~mask`. `ovr_val` is unchanged.
- Any other cmd is treated as NOP and counts one error.
- `buf_out_hasdata` and `buf_out_arm_ack` pass through 2-flop synchronizers before use.
- State ST_RST: one cycle, then ST_ARM.
- State ST_ARM: wait for `usb_configured`, then hold `buf_out_arm`=1 until the synced ack is 1. Then drive `buf_out_arm`=0 and go to ST_ARM_ACK.
- State ST_ARM_ACK: wait for the synced ack to return to 0, then ST_WAIT.
- State ST_WAIT: on synced `hasdata`, latch `buf_out_len`, set `rec_idx`=0, go to ST_FETCH.
  - Number of records is `len[9:3]`.
  - A nonzero `len[2:0]` counts one error; the trailing bytes are ignored.
  - A record count of 0 goes straight to ST_ARM.
- State ST_FETCH: issue addresses `{rec_idx,3'd0}` through `{rec_idx,3'd7}` on 8 consecutive cycles and shift the bytes into the record register. Then ST_DELAY.
- State ST_DELAY: load a 24-bit down-counter with `delay` and count to 0. Then ST_APPLY.
- State ST_APPLY: perform the command for one cycle and increment `rec_count` for cmd 0x01 and 0x02. Then:
  - if `rec_idx` is the last record, go to ST_ARM;
  - otherwise increment `rec_idx` and go to ST_FETCH.
- `usb_configured` falling in any state:
  - Clear `ovr_en`.
  - Abandon the current buffer.
  - Go to ST_ARM, which then waits for reconfiguration.
- Asynchronous reset mid-operation: all outputs return to their reset values immediately and the FSM enters ST_RST. Stale buffer contents are discarded by the re-arm.

## Timing
- Call cycle F0 the first ST_FETCH cycle.
- Byte k address is issued on cycle F0+k; that byte is captured on cycle F0+k+2.
- The record is complete at F0+9, and ST_DELAY is entered on F0+10.
- APPLY takes effect on `ovr_*` at F0+11+delay. With delay=0 this is F0+11.
- The next record's F0 is the cycle after APPLY, so back-to-back zero-delay records are 12 cycles apart.
- `hasdata` rising to ST_FETCH takes 3 cycles: 2 for the synchronizer, 1 for the latch.
- The arm handshake is a 4-phase handshake: arm up, ack up, arm down, ack down.

## Configuration
- `RS232_PLAYER_ERRCNT_EN` defined: `err_count` is implemented as described.
- Not defined: `err_count` is tied to 0, and no error-detection logic is synthesised. Command decode is otherwise identical, so unknown commands are still treated as NOP.

## Structure
- Package `rs232_player_pkg` holds:
  - command codes `CMD_NOP`, `CMD_APPLY`, `CMD_RELEASE`;
  - record field bit offsets;
  - line bit-map constants;
  - the 6-bit state encodings.
- Sub-module `rs232_player_sync` is a 2-flop synchronizer with asynchronous active-low reset. It is instantiated once for `hasdata` and once for `arm_ack`.

## Test plan
- One record `01 000000 FFFF 5555`, `len`=8 → after the arm handshake, `ovr_en`=FFFF and `ovr_val`=5555 at F0+11; `rec_count`=1; `buf_out_arm` reasserted.
- Two records: APPLY mask A000 level 2000 delay 100, then RELEASE mask 8000 delay 0 → `ovr_en`=A000 and `ovr_val`=2000 at F0+111; `ovr_en`=2000 12 cycles later.
- `len`=0 → no `buf_out_addr` activity; `buf_out_arm` reasserted within 4 cycles; no counter change.
- `len`=13 with cmd 0x7E → one record fetched and treated as NOP; `ovr_*` unchanged; `err_count`=2 with the macro, 0 without.
- `reset_n` low during ST_DELAY → `ovr_en`=0, `busy`=1, `buf_out_arm`=0 immediately; after release, ST_RST then the arm handshake restarts.
- `usb_configured` drops mid-FETCH → `ovr_en`=0 and the FSM waits in ST_ARM with `buf_out_arm`=0 until `usb_configured` returns.
